// File: rtl/crc_16_pkg.sv
// Shared types, defaults and the serial step function for the CRC-16/ANSI generator/checker pair.
package crc_16_pkg;

  typedef logic [15:0] crc_16_hash;

  localparam crc_16_hash CRC_16_POLY = 16'h8005;
  localparam crc_16_hash CRC_16_INIT = 16'h0000;

  typedef enum logic [1:0] {IDLE, DATA, CHECK} crc_16_state_e;

  function automatic crc_16_hash crc_16_step(input logic b, input crc_16_hash h,
                                             input crc_16_hash poly);
    crc_16_hash sh;
    sh = {h[14:0], 1'b0};
    return (b ^ h[15]) ? (sh ^ poly) : sh;
  endfunction

endpackage

// File: rtl/crc_16_lfsr.sv
// Serial CRC-16 LFSR: load seeds from init_i while absorbing bit_i, en_i steps the running value.
module crc_16_lfsr
  import crc_16_pkg::*;
#(
  parameter crc_16_hash POLY = CRC_16_POLY
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  crc_16_hash init_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic       bit_i,
  output crc_16_hash crc_o
);

  crc_16_hash crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (load_i)    crc_d = crc_16_step(bit_i, init_i, POLY);
    else if (en_i) crc_d = crc_16_step(bit_i, crc_q, POLY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= init_i;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc_16_ansi_checker.sv
// Receive-side CRC-16/ANSI checker: payload LSB first, then 16 CRC bits MSB first; zero residue = match.
module crc_16_ansi_checker
  import crc_16_pkg::*;
#(
  parameter crc_16_hash POLY     = CRC_16_POLY,
  parameter crc_16_hash CRC_INIT = CRC_16_INIT,
  parameter int         DATA_W   = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        sof_i,
  input  logic        data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        crc_ok_o,
  output logic [15:0] crc_o,
  output logic [15:0] rx_crc_o
);

  localparam int CNT_W = $clog2(DATA_W + 16);
  // cnt holds bits accepted so far; its largest stored value is DATA_W+15, so it never wraps
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_CHK  = CNT_W'(DATA_W + 15);

  crc_16_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  crc_16_hash       crc_q, crc_d;
  crc_16_hash       rx_q, rx_d;

  logic       lf_load, lf_en;
  crc_16_hash lf_crc, lf_nxt;

  crc_16_lfsr #(.POLY(POLY)) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (CRC_INIT),
    .load_i (lf_load),
    .en_i   (lf_en),
    .bit_i  (data_i),
    .crc_o  (lf_crc)
  );

  // Value the LFSR takes on this accept; used for the payload latch and the residue test
  assign lf_nxt = crc_16_step(data_i, lf_load ? CRC_INIT : lf_crc, POLY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    lf_load = 1'b0;
    lf_en   = 1'b0;
    if (valid_i && sof_i) begin
      // sof in any state starts a fresh frame; an unfinished one is dropped silently
      lf_load = 1'b1;
      cnt_d   = CNT_W'(1);
      ok_d    = 1'b0;
      crc_d   = '0;
      rx_d    = '0;
      if (DATA_W == 1) begin
        state_d = CHECK;
        crc_d   = lf_nxt;
      end else begin
        state_d = DATA;
      end
    end else if (valid_i) begin
      case (state_q)
        DATA: begin
          lf_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_DATA) begin
            crc_d   = lf_nxt;
            state_d = CHECK;
          end
        end
        CHECK: begin
          lf_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          rx_d  = {rx_q[14:0], data_i};
          if (cnt_q == LAST_CHK) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            ok_d    = (lf_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      crc_q   <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign crc_ok_o = ok_q;
  assign crc_o    = crc_q;
  assign rx_crc_o = rx_q;

endmodule
